// File: rtl/regfile_wr_arbiter.sv
// Two-requester write arbiter (A = ALU writeback, B = load writeback) in front of a
// single registered register-file write port. Optional forwarding taps: WR_ARB_FWD_EN.
module regfile_wr_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        a_valid,
  input  logic [4:0]  a_addr,
  input  logic [31:0] a_data,
  input  logic [3:0]  a_ben,
  output logic        a_ready,
  input  logic        b_valid,
  input  logic [4:0]  b_addr,
  input  logic [31:0] b_data,
  input  logic [3:0]  b_ben,
  output logic        b_ready,
  input  logic        prio_b,
  input  logic        freeze,
  output logic        rf_wr,
  output logic [4:0]  rf_addr,
  output logic [31:0] rf_data,
  output logic [3:0]  rf_ben,
  input  logic [4:0]  q_addr0,
  input  logic [4:0]  q_addr1,
  output logic        q_busy0,
  output logic        q_busy1
`ifdef WR_ARB_FWD_EN
  ,
  output logic        fwd_hit0,
  output logic        fwd_hit1,
  output logic [31:0] fwd_data0,
  output logic [31:0] fwd_data1
`endif
);

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
    logic [3:0]  ben;
  } wr_req_t;

  logic    last_b_q, last_b_d;
  logic    run_q, run_d;
  logic    rf_wr_q, rf_wr_d;
  wr_req_t rf_q, rf_d;
  logic    gnt_a, gnt_b;
  wr_req_t sel;

  // run_q holds off grants until the cycle after rst_n is first sampled high.
  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (rst_n && run_q && !freeze) begin
      if (a_valid && b_valid) begin
        if (prio_b || !last_b_q) gnt_b = 1'b1;
        else                     gnt_a = 1'b1;
      end else begin
        gnt_a = a_valid;
        gnt_b = b_valid;
      end
    end
  end

  assign a_ready = gnt_a;
  assign b_ready = gnt_b;

  always_comb begin
    sel      = gnt_b ? '{addr: b_addr, data: b_data, ben: b_ben}
                     : '{addr: a_addr, data: a_data, ben: a_ben};
    run_d    = 1'b1;
    last_b_d = last_b_q;
    if (gnt_a) last_b_d = 1'b0;
    if (gnt_b) last_b_d = 1'b1;
    rf_wr_d  = 1'b0;
    rf_d     = rf_q;
    if (gnt_a || gnt_b) begin
      rf_d    = sel;
      // writes to r0 or with no byte lanes are consumed but never reach the file
      rf_wr_d = (sel.addr != 5'd0) && (sel.ben != 4'd0);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_b_q <= 1'b1;
      run_q    <= 1'b0;
      rf_wr_q  <= 1'b0;
      rf_q     <= '0;
    end else begin
      last_b_q <= last_b_d;
      run_q    <= run_d;
      rf_wr_q  <= rf_wr_d;
      rf_q     <= rf_d;
    end
  end

  assign rf_wr   = rf_wr_q;
  assign rf_addr = rf_q.addr;
  assign rf_data = rf_q.data;
  assign rf_ben  = rf_q.ben;

  assign q_busy0 = (q_addr0 != 5'd0) &&
                   ((rf_wr_q && q_addr0 == rf_q.addr) ||
                    (a_valid && q_addr0 == a_addr) || (b_valid && q_addr0 == b_addr));
  assign q_busy1 = (q_addr1 != 5'd0) &&
                   ((rf_wr_q && q_addr1 == rf_q.addr) ||
                    (a_valid && q_addr1 == a_addr) || (b_valid && q_addr1 == b_addr));

`ifdef WR_ARB_FWD_EN
  // Only full-word writes can be forwarded; partial writes must go through the file.
  logic fwd_ok;
  assign fwd_ok    = rf_wr_q && (rf_q.addr != 5'd0) && (rf_q.ben == 4'hF);
  assign fwd_hit0  = fwd_ok && (q_addr0 == rf_q.addr);
  assign fwd_hit1  = fwd_ok && (q_addr1 == rf_q.addr);
  assign fwd_data0 = fwd_hit0 ? rf_q.data : 32'd0;
  assign fwd_data1 = fwd_hit1 ? rf_q.data : 32'd0;
`endif

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter: inputs change 1ns after posedge, checks 1ns later.
module tb_regfile_wr_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_valid, b_valid, prio_b, freeze;
  logic [4:0]  a_addr, b_addr, q_addr0, q_addr1;
  logic [31:0] a_data, b_data;
  logic [3:0]  a_ben, b_ben;
  logic        a_ready, b_ready, rf_wr, q_busy0, q_busy1;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;
  logic [3:0]  rf_ben;
`ifdef WR_ARB_FWD_EN
  logic        fwd_hit0, fwd_hit1;
  logic [31:0] fwd_data0, fwd_data1;
`endif
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  regfile_wr_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ben(a_ben), .a_ready(a_ready),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ben(b_ben), .b_ready(b_ready),
    .prio_b(prio_b), .freeze(freeze),
    .rf_wr(rf_wr), .rf_addr(rf_addr), .rf_data(rf_data), .rf_ben(rf_ben),
    .q_addr0(q_addr0), .q_addr1(q_addr1), .q_busy0(q_busy0), .q_busy1(q_busy1)
`ifdef WR_ARB_FWD_EN
    , .fwd_hit0(fwd_hit0), .fwd_hit1(fwd_hit1), .fwd_data0(fwd_data0), .fwd_data1(fwd_data1)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv_a(input logic v, input logic [4:0] ad, input logic [31:0] d, input logic [3:0] be);
    a_valid = v; a_addr = ad; a_data = d; a_ben = be;
  endtask

  task automatic drv_b(input logic v, input logic [4:0] ad, input logic [31:0] d, input logic [3:0] be);
    b_valid = v; b_addr = ad; b_data = d; b_ben = be;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    rst_n = 1'b0; prio_b = 1'b0; freeze = 1'b0; q_addr0 = 5'd0; q_addr1 = 5'd0;
    drv_a(1'b1, 5'd4, 32'hDEAD, 4'hF);
    drv_b(1'b0, 5'd0, 32'd0, 4'h0);
    #1;
    chk("rst_a_ready", a_ready, 0);
    tick(); tick();
    chk("rst_rf_wr", rf_wr, 0);
    chk("rst_rf_addr", rf_addr, 0);
    chk("rst_rf_data", rf_data, 0);
    chk("rst_rf_ben", rf_ben, 0);
    chk("rst_a_ready2", a_ready, 0);
    drv_a(1'b0, 5'd0, 32'd0, 4'h0);
    rst_n = 1'b1;
    tick();

    // single requester A
    drv_a(1'b1, 5'd5, 32'h12345678, 4'hF);
    q_addr0 = 5'd5; q_addr1 = 5'd6;
    #1;
    chk("a_only_ready", a_ready, 1);
    chk("a_only_bready", b_ready, 0);
    chk("busy_a_valid", q_busy0, 1);
    chk("busy_miss", q_busy1, 0);
    tick();
    drv_a(1'b0, 5'd0, 32'd0, 4'h0);
    #1;
    chk("a_only_wr", rf_wr, 1);
    chk("a_only_addr", rf_addr, 5);
    chk("a_only_data", rf_data, 32'h12345678);
    chk("a_only_ben", rf_ben, 4'hF);
    chk("busy_rf_wr", q_busy0, 1);

    // round robin after reset: A, B, A
    do_reset();
    chk("rr_rst_wr", rf_wr, 0);
    drv_a(1'b1, 5'd1, 32'hA1, 4'hF);
    drv_b(1'b1, 5'd2, 32'hB2, 4'hF);
    #1;
    chk("rr1_a", a_ready, 1);
    chk("rr1_b", b_ready, 0);
    tick();
    drv_a(1'b1, 5'd3, 32'hA3, 4'hF);
    #1;
    chk("rr1_wr", rf_wr, 1);
    chk("rr1_addr", rf_addr, 1);
    chk("rr2_b", b_ready, 1);
    chk("rr2_a", a_ready, 0);
    tick();
    drv_b(1'b1, 5'd4, 32'hB4, 4'hF);
    #1;
    chk("rr2_wr", rf_wr, 1);
    chk("rr2_data", rf_data, 32'hB2);
    chk("rr3_a", a_ready, 1);
    tick();
    drv_a(1'b0, 5'd0, 32'd0, 4'h0);
    drv_b(1'b0, 5'd0, 32'd0, 4'h0);
    #1;
    chk("rr3_wr", rf_wr, 1);
    chk("rr3_data", rf_data, 32'hA3);
    tick();
    chk("idle_wr", rf_wr, 0);
    chk("idle_hold_addr", rf_addr, 3);

    // fixed priority B; A waits until B drops
    prio_b = 1'b1;
    drv_a(1'b1, 5'd10, 32'hAA, 4'hF);
    drv_b(1'b1, 5'd11, 32'hB11, 4'hF);
    q_addr1 = 5'd11;
    #1;
    chk("pb1_b", b_ready, 1);
    chk("pb1_a", a_ready, 0);
    chk("busy_b_valid", q_busy1, 1);
    tick();
    drv_b(1'b1, 5'd12, 32'hB12, 4'hF);
    #1;
    chk("pb2_b", b_ready, 1);
    chk("pb2_a", a_ready, 0);
    tick();
    drv_b(1'b0, 5'd0, 32'd0, 4'h0);
    #1;
    chk("pb2_data", rf_data, 32'hB12);
    chk("pb3_a", a_ready, 1);
    tick();
    drv_a(1'b0, 5'd0, 32'd0, 4'h0);
    #1;
    chk("pb3_addr", rf_addr, 10);

    // last-grant tracks grants made under prio_b
    drv_a(1'b1, 5'd13, 32'hA13, 4'hF);
    drv_b(1'b1, 5'd14, 32'hB14, 4'hF);
    #1;
    chk("lg_b", b_ready, 1);
    tick();
    prio_b = 1'b0;
    drv_b(1'b1, 5'd15, 32'hB15, 4'hF);
    #1;
    chk("lg_a", a_ready, 1);
    chk("lg_bnot", b_ready, 0);

    // freeze blocks both
    freeze = 1'b1;
    tick();
    #1;
    chk("frz_a", a_ready, 0);
    chk("frz_b", b_ready, 0);
    tick();
    chk("frz_wr", rf_wr, 0);
    freeze = 1'b0;
    drv_a(1'b0, 5'd0, 32'd0, 4'h0);
    drv_b(1'b0, 5'd0, 32'd0, 4'h0);
    tick();

    // writes to r0 and with no byte enables are dropped
    drv_b(1'b1, 5'd0, 32'hFFFFFFFF, 4'hF);
    q_addr0 = 5'd0;
    #1;
    chk("r0_bready", b_ready, 1);
    chk("r0_busy", q_busy0, 0);
    tick();
    drv_b(1'b0, 5'd0, 32'd0, 4'h0);
    drv_a(1'b1, 5'd7, 32'h77, 4'h0);
    #1;
    chk("r0_wr", rf_wr, 0);
    chk("ben0_aready", a_ready, 1);
    tick();
    drv_a(1'b0, 5'd0, 32'd0, 4'h0);
    #1;
    chk("ben0_wr", rf_wr, 0);

    // same destination: B (last grant was A) then A, file sees A last
    drv_a(1'b1, 5'd9, 32'hA9, 4'hF);
    drv_b(1'b1, 5'd9, 32'hB9, 4'hF);
    tick();
    drv_b(1'b0, 5'd0, 32'd0, 4'h0);
    #1;
    chk("same1_data", rf_data, 32'hB9);
    tick();
    drv_a(1'b0, 5'd0, 32'd0, 4'h0);
    #1;
    chk("same2_data", rf_data, 32'hA9);
    chk("same2_wr", rf_wr, 1);

    // reset cancels a pending write and blocks A until released
    drv_a(1'b1, 5'd8, 32'h88, 4'hF);
    tick();
    rst_n = 1'b0;
    #1;
    chk("rc_pend_wr", rf_wr, 1);
    chk("rc_pend_addr", rf_addr, 8);
    chk("rc_aready", a_ready, 0);
    tick();
    chk("rc_wr", rf_wr, 0);
    chk("rc_addr", rf_addr, 0);
    chk("rc_data", rf_data, 0);
    chk("rc_ben", rf_ben, 0);
    chk("rc_aready2", a_ready, 0);
    rst_n = 1'b1;
    tick();
    chk("rc_regrant", a_ready, 1);
    tick();
    drv_a(1'b0, 5'd0, 32'd0, 4'h0);
    #1;
    chk("rc_regrant_wr", rf_wr, 1);

`ifdef WR_ARB_FWD_EN
    drv_a(1'b1, 5'd30, 32'd128, 4'hF);
    tick();
    drv_a(1'b0, 5'd0, 32'd0, 4'h0);
    q_addr1 = 5'd30; q_addr0 = 5'd29;
    #1;
    chk("fwd_hit1", fwd_hit1, 1);
    chk("fwd_data1", fwd_data1, 128);
    chk("fwd_busy1", q_busy1, 1);
    chk("fwd_hit0", fwd_hit0, 0);
    chk("fwd_data0", fwd_data0, 0);
    drv_a(1'b1, 5'd30, 32'd128, 4'h3);
    tick();
    drv_a(1'b0, 5'd0, 32'd0, 4'h0);
    #1;
    chk("fwd_part_hit1", fwd_hit1, 0);
    chk("fwd_part_data1", fwd_data1, 0);
    chk("fwd_part_busy1", q_busy1, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/regfile_wr_arbiter.md
REGFILE_WR_ARBITER -- requirements
Module: regfile_wr_arbiter

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have: rst_n  in  1  reset, synchronous, active-low.
REQ-003 SHALL have: a_valid in 1, a_addr in 5, a_data in 32, a_ben in 4: requester A (ALU writeback) write request, destination, data, byte enables.
REQ-004 SHALL have: a_ready  out  1  A request accepted this cycle.
REQ-005 SHALL have: b_valid in 1, b_addr in 5, b_data in 32, b_ben in 4: requester B (load writeback) write request, destination, data, byte enables.
REQ-006 SHALL have: b_ready  out  1  B request accepted this cycle.
REQ-007 SHALL have: prio_b  in  1  1 = fixed priority to B; 0 = round-robin.
REQ-008 SHALL have: freeze  in  1  1 = no grants this cycle.
REQ-009 SHALL have: rf_wr out 1, rf_addr out 5, rf_data out 32, rf_ben out 4: registered register-file write port (RegWr, Rd_addr, Rd_in, Rd_Byte_w_en).
REQ-010 SHALL have: q_addr0, q_addr1  in  5 each  hazard query addresses (Rs, Rt).
REQ-011 SHALL have: q_busy0, q_busy1  out  1 each  pending write to queried register.

Function
REQ-012 Handshake SHALL be: transfer when valid && ready on a rising edge; requester holds valid, addr, data and ben stable until ready; ready combinational from valids, prio_b, freeze and last-grant state.
REQ-013 At most one of a_ready, b_ready SHALL be 1 per cycle; both SHALL be 0 when freeze=1 or rst_n=0.
REQ-014 Single valid requester, freeze=0: SHALL be granted in the same cycle.
REQ-015 Both valid, prio_b=1: B SHALL be granted.
REQ-016 Both valid, prio_b=0: grant SHALL go to the requester not granted last; last-grant flop resets to B, so A wins the first contention.
REQ-017 Last-grant flop SHALL update only on an actual grant, including grants under prio_b=1.
REQ-018 Accepted request at edge N SHALL drive rf_addr/rf_data/rf_ben after edge N with rf_wr=1 for exactly that cycle; latency one cycle.
REQ-019 Accepted request with addr=0 or ben=4'b0000 SHALL be consumed with rf_wr=0 in the following cycle.
REQ-020 No grant in a cycle SHALL give rf_wr=0 next cycle; rf_addr/rf_data/rf_ben hold their previous values.
REQ-021 Back-to-back grants SHALL produce rf_wr=1 on consecutive cycles, one write per cycle, no bubble.
REQ-022 q_busyK SHALL be 1 iff q_addrK!=0 and it equals rf_addr while rf_wr=1, or a_addr while a_valid=1, or b_addr while b_valid=1; purely combinational.
REQ-023 A and B targeting the same register SHALL be serialized in grant order; register file sees the later grant last.

Reset
REQ-024 While rst_n=0 at an edge: rf_wr=0, rf_addr=0, rf_data=0, rf_ben=0, last-grant=B; forwarding outputs 0 when compiled in.
REQ-025 Reset asserted with rf_wr=1 SHALL cancel the pending write (rf_wr=0 next cycle); requests presented during reset SHALL NOT be accepted.
REQ-026 First grant possible in the cycle after rst_n samples 1.

Configuration
REQ-027 Macro WR_ARB_FWD_EN defined: SHALL add outputs fwd_hit0, fwd_hit1 (1 bit) and fwd_data0, fwd_data1 (32 bit); fwd_hitK=1 iff rf_wr=1, rf_addr!=0, rf_ben=4'b1111 and q_addrK=rf_addr; fwd_dataK=rf_data when hit, else 0.
REQ-028 WR_ARB_FWD_EN undefined: SHALL omit those ports; all other behaviour identical.

Verification
REQ-029 A only: a_valid=1, a_addr=5, a_data=32'h12345678, ben=F -> a_ready=1 same cycle; next cycle rf_wr=1, rf_addr=5, rf_data=32'h12345678.
REQ-030 Both valid 3 cycles, prio_b=0, after reset -> grants A,B,A; rf_wr=1 three consecutive cycles.
REQ-031 Both valid, prio_b=1 -> b_ready=1 every cycle, a_ready=0 until b_valid drops, then A granted.
REQ-032 B request addr=0, data=32'hFFFFFFFF -> b_ready=1; next cycle rf_wr=0; q_busy0=0 for q_addr0=0.
REQ-033 A granted addr=8, then rst_n=0 on next edge -> rf_wr=0, all rf_* zero; A not regranted until rst_n=1.
REQ-034 With WR_ARB_FWD_EN: write addr=30, data=32'd128, ben=F; q_addr1=30 -> fwd_hit1=1, fwd_data1=128, q_busy1=1; repeat with ben=4'b0011 -> fwd_hit1=0, q_busy1=1.
